// File: rtl/vga_row_buffer.sv
// Double-buffered row store between a burst memory reader and the VGA pixel path.
// Row r always lands in bank r[0]; the display side reads bank drow[0].
module vga_row_buffer #(
    parameter logic [25:0] FRAME_BASE    = 26'h0,
    parameter int          WORDS_PER_ROW = 80,
    parameter int          ROWS          = 480
) (
    input  logic         clk_25M,
    input  logic         rst_25M,
    input  logic         start_frame,
    input  logic         start_row,
    input  logic [9:0]   h_counter,
    output logic [15:0]  pixel_data,
    output logic         rd_req,
    output logic [25:0]  rd_addr,
    input  logic         rd_ready,
    input  logic         rd_valid,
    input  logic [127:0] rd_data,
    output logic         underrun
);

    localparam int              AW     = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [AW-1:0]   LAST   = AW'(WORDS_PER_ROW - 1);
    localparam logic [9:0]      ROWS_L = 10'(ROWS);
    localparam logic [7:0]      WPR_L  = 8'(WORDS_PER_ROW);
    localparam logic [25:0]     WPR_A  = 26'(WORDS_PER_ROW);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state, state_d;

    logic [1:0]    pending;
    logic [8:0]    frow, drow;
    logic [6:0]    outstanding;
    logic [AW-1:0] widx, wr_idx, ridx;
    logic [1:0]    bank_vld, vld_d;
    logic [127:0]  mem [2][WORDS_PER_ROW];
    logic [127:0]  rd_word;

    logic accept, fill, wr_en, done, frow_ok, next_row_in, inc, h_in;

    assign accept      = rd_req & rd_ready;
    assign fill        = (state == REQ) || (state == WAIT);
    // Data arriving alongside a frame restart belongs to the abandoned fetch.
    assign wr_en       = rd_valid & fill & ~start_frame;
    assign done        = wr_en & (state == WAIT) & (wr_idx == LAST);
    assign frow_ok     = {1'b0, frow} < ROWS_L;
    assign next_row_in = ({1'b0, drow} + 10'd1) < ROWS_L;
    assign inc         = start_row & frow_ok;

    assign rd_req  = (state == REQ);
    assign rd_addr = rd_req ? FRAME_BASE + 26'(frow) * WPR_A + 26'(widx) : '0;

    // Columns past the end of the row fold onto word 0 so the read stays in range.
    assign h_in    = {1'b0, h_counter[9:3]} < WPR_L;
    assign ridx    = h_in ? AW'(h_counter[9:3]) : '0;
    assign rd_word = mem[drow[0]][ridx];

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pending != 2'd0 && frow_ok) state_d = REQ;
            REQ:     if (accept && widx == LAST)     state_d = WAIT;
            WAIT:    if (done)                       state_d = IDLE;
            DRAIN:   if (outstanding == 7'd0)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start_frame && fill) state_d = DRAIN;
    end

    // A released bank is no longer valid; a completed fetch validates its bank.
    always_comb begin
        vld_d = bank_vld;
        if (start_row) vld_d[drow[0]] = 1'b0;
        if (done)      vld_d[frow[0]] = 1'b1;
    end

    always_ff @(posedge clk_25M) begin
        if (rst_25M) begin
            state       <= IDLE;
            pending     <= '0;
            frow        <= '0;
            drow        <= '0;
            outstanding <= '0;
            widx        <= '0;
            wr_idx      <= '0;
            bank_vld    <= '0;
            underrun    <= 1'b0;
            pixel_data  <= '0;
        end else begin
            state      <= state_d;
            pixel_data <= rd_word[{h_counter[2:0], 4'b0000} +: 16];

            // Stale responses after reset find the counter at 0 and are not counted.
            case ({accept, rd_valid && outstanding != 7'd0})
                2'b10:   outstanding <= outstanding + 7'd1;
                2'b01:   outstanding <= outstanding - 7'd1;
                default: ;
            endcase

            if (start_row && !bank_vld[~drow[0]] && next_row_in)
                underrun <= 1'b1;

            if (start_frame) begin
                frow     <= '0;
                drow     <= '0;
                pending  <= 2'd2;
                widx     <= '0;
                wr_idx   <= '0;
                bank_vld <= '0;
            end else begin
                bank_vld <= vld_d;
                if (accept) widx   <= (widx == LAST) ? '0 : widx + 1'b1;
                if (wr_en)  wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
                if (done)   frow   <= frow + 9'd1;
                if (start_row) drow <= drow + 9'd1;
                if (inc && !done) begin
                    if (pending != 2'd2) pending <= pending + 2'd1;
                end else if (done && !inc) begin
                    pending <= pending - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_25M) begin
        if (!rst_25M && wr_en) mem[frow[0]][wr_idx] <= rd_data;
    end

endmodule

// File: tb/tb_vga_row_buffer.sv
// Directed bench for vga_row_buffer with an in-order, ~4-cycle-latency memory responder.
module tb_vga_row_buffer;

    logic         clk_25M = 1'b0;
    logic         rst_25M, start_frame, start_row;
    logic [9:0]   h_counter;
    logic [15:0]  pixel_data;
    logic         rd_req, rd_ready, rd_valid, underrun;
    logic [25:0]  rd_addr;
    logic [127:0] rd_data;

    always #20 clk_25M = ~clk_25M;

    vga_row_buffer dut (
        .clk_25M(clk_25M), .rst_25M(rst_25M), .start_frame(start_frame),
        .start_row(start_row), .h_counter(h_counter), .pixel_data(pixel_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .underrun(underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {logic [25:0] addr; int unsigned due;} rsp_t;
    rsp_t        rq[$];
    logic [25:0] acc_log[$];
    int unsigned cyc = 0;
    int          n_valid = 0;
    bit          hold = 1'b0;

    // Pixel at column c of row r reads back as {r[5:0], c[9:0]}.
    function automatic logic [127:0] word_of(logic [25:0] a);
        logic [127:0] w;
        int row, col0;
        row  = int'(a) / 80;
        col0 = (int'(a) % 80) * 8;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = {6'(row), 10'(col0 + k)};
        return w;
    endfunction

    always @(negedge clk_25M) begin
        cyc++;
        if (rd_req && rd_ready) begin
            acc_log.push_back(rd_addr);
            rq.push_back('{rd_addr, cyc + 4});
        end
        if (!hold && rq.size() > 0 && rq[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = word_of(rq[0].addr);
            rq.delete(0);
            n_valid++;
        end else begin
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_25M);
            #1;
        end
    endtask

    task automatic pulse_sf();
        start_frame = 1'b1; step(); start_frame = 1'b0;
    endtask

    task automatic pulse_sr();
        start_row = 1'b1; step(); start_row = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag, output bit ok);
        int k;
        k = 0;
        while (acc_log.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (acc_log.size() >= n);
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        bit seq_ok;
        int n0, sz;

        rst_25M = 1'b1; start_frame = 1'b0; start_row = 1'b0;
        h_counter = '0; rd_ready = 1'b1;
        step(3);
        check("rst_rd_req",   32'(rd_req), 32'd0);
        check("rst_rd_addr",  32'(rd_addr), 32'd0);
        check("rst_pixel",    32'(pixel_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_25M = 1'b0;
        step(10);
        check("no_fetch_before_frame", 32'(acc_log.size()), 32'd0);

        // Initial frame fill: rows 0 and 1, then idle.
        pulse_sf();
        wait_acc(160, 600, "fill_timeout", ok);
        step(20);
        check("fill_count", 32'(acc_log.size()), 32'd160);
        seq_ok = 1'b1;
        foreach (acc_log[i]) if (acc_log[i] != 26'(i)) seq_ok = 1'b0;
        check("fill_seq", 32'(seq_ok), 32'd1);
        check("fill_a0",   32'(acc_log[0]),   32'd0);
        check("fill_a79",  32'(acc_log[79]),  32'd79);
        check("fill_a80",  32'(acc_log[80]),  32'd80);
        check("fill_a159", 32'(acc_log[159]), 32'd159);
        check("fill_idle", 32'(rd_req), 32'd0);

        // Row 0 on display: every column, then out-of-range columns.
        for (int i = 0; i < 640; i++) begin
            h_counter = 10'(i);
            step();
            check("pix_row0", 32'(pixel_data), 32'(i));
        end
        h_counter = 10'd9;   step(); check("pix_h9",  32'(pixel_data), 32'h0009);
        h_counter = 10'd700; step(); check("pix_h700_known", 32'($isunknown(pixel_data)), 32'd0);
        h_counter = 10'd1023; step(); check("pix_h1023_known", 32'($isunknown(pixel_data)), 32'd0);

        // First row advance: fetch row 2 into bank 0, display row 1.
        acc_log.delete();
        pulse_sr();
        wait_acc(80, 300, "row2_timeout", ok);
        step(20);
        check("row2_count", 32'(acc_log.size()), 32'd80);
        check("row2_first", 32'(acc_log[0]),  32'd160);
        check("row2_last",  32'(acc_log[79]), 32'd239);
        check("row2_no_underrun", 32'(underrun), 32'd0);
        h_counter = 10'd9;   step(); check("pix_row1_h9",   32'(pixel_data), 32'h0409);
        h_counter = 10'd639; step(); check("pix_row1_h639", 32'(pixel_data), 32'h067F);

        acc_log.delete();
        pulse_sr();
        wait_acc(80, 300, "row3_timeout", ok);
        step(20);
        check("row3_first", 32'(acc_log[0]), 32'd240);
        h_counter = 10'd9; step(); check("pix_row2_h9", 32'(pixel_data), 32'h0809);
        check("row3_no_underrun", 32'(underrun), 32'd0);

        // Frame restart with 5 responses held back: drain, then restart at base.
        acc_log.delete();
        hold = 1'b1;
        pulse_sf();
        n0 = 0;
        while (acc_log.size() < 5 && n0 < 50) begin step(); n0++; end
        rd_ready = 1'b0;
        check("drain_setup_5", 32'(acc_log.size()), 32'd5);
        n0 = n_valid;
        acc_log.delete();
        pulse_sf();
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("drain_rd_req", 32'(rd_req), 32'd0);
        end
        hold = 1'b0;
        sz = 0;
        while (n_valid < n0 + 5 && sz < 50) begin step(); sz++; end
        check("drain_responses", 32'(n_valid - n0), 32'd5);
        check("drain_no_accept", 32'(acc_log.size()), 32'd0);
        wait_acc(1, 20, "restart_timeout", ok);
        check("restart_addr", 32'(acc_log[0]), 32'd0);
        wait_acc(160, 600, "refill_timeout", ok);
        step(20);

        // Underrun: advance while row 1 cannot be fetched; sticky through a frame start.
        rd_ready = 1'b0;
        check("pre_underrun", 32'(underrun), 32'd0);
        pulse_sf();
        step(2);
        pulse_sr();
        step();
        check("underrun_set", 32'(underrun), 32'd1);
        pulse_sf();
        step(3);
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Reset mid-fetch abandons it; late responses are ignored.
        acc_log.delete();
        rd_ready = 1'b1;
        wait_acc(30, 100, "midfetch_timeout", ok);
        rst_25M = 1'b1;
        step();
        check("midrst_rd_req",   32'(rd_req), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_pixel",    32'(pixel_data), 32'd0);
        rst_25M = 1'b0;
        sz = acc_log.size();
        step(20);
        check("post_rst_idle", 32'(acc_log.size()), 32'(sz));

        // Whole frame: 478 advances fetch rows 2..479, the 479th fetches nothing.
        acc_log.delete();
        pulse_sf();
        wait_acc(160, 600, "frame_fill_timeout", ok);
        step(10);
        for (int r = 0; r < 478 && ok; r++) begin
            pulse_sr();
            wait_acc(160 + 80 * (r + 1), 300, "frame_row_timeout", ok);
            step(8);
        end
        step(20);
        pulse_sr();
        step(200);
        check("frame_total", 32'(acc_log.size()), 32'd38400);
        check("frame_last",  32'(acc_log[acc_log.size() - 1]), 32'd38399);
        check("frame_idle",  32'(rd_req), 32'd0);
        check("frame_no_underrun", 32'(underrun), 32'd0);
        h_counter = 10'd9; step(); check("pix_row479_h9", 32'(pixel_data), 32'h7C09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_row_buffer.md
VGA_ROW_BUFFER -- requirements
Module: vga_row_buffer

Interface
REQ-001 The block SHALL have parameter FRAME_BASE, default 26'h0, meaning the memory word address of pixel row 0.
REQ-002 The block SHALL have parameter WORDS_PER_ROW, default 80, meaning the number of 128-bit words per row (8 pixels × 16 bits per word, 640 pixels).
REQ-003 The block SHALL have parameter ROWS, default 480, meaning the number of visible rows per frame.
REQ-004 Port clk_25M, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 Port rst_25M, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port start_frame, input, 1 bit: one-cycle pulse from the VGA timing stage meaning "begin a new frame".
REQ-007 Port start_row, input, 1 bit: one-cycle pulse meaning "the current display row is finished".
REQ-008 Port h_counter, input, 10 bits: current pixel column from the VGA timing stage.
REQ-009 Port pixel_data, output, 16 bits: pixel for column h_counter of the current display row.
REQ-010 Port rd_req, output, 1 bit: memory read address valid.
REQ-011 Port rd_addr, output, 26 bits: memory word address.
REQ-012 Port rd_ready, input, 1 bit: memory accepts the address; an address transfers on a cycle where rd_req and rd_ready are both 1.
REQ-013 Port rd_valid, input, 1 bit: the read data word is valid; responses return in request order, with no limit on outstanding requests.
REQ-014 Port rd_data, input, 128 bits: read data word.
REQ-015 Port underrun, output, 1 bit: sticky flag set when a row is displayed before its fetch has completed.

Function
REQ-016 Storage SHALL be two banks of WORDS_PER_ROW × 128 bits; row r SHALL always be stored in bank r[0].
REQ-017 The display row counter drow (9 bits) SHALL be cleared to 0 on start_frame and incremented by 1 on start_row; the display bank SHALL be drow[0].
REQ-018 pixel_data SHALL be registered and equal lane h_counter[2:0] of word h_counter[9:3] of the display bank, with 1-cycle latency; lane k is rd_data[16k+15:16k], with no byte swap.
REQ-019 For h_counter ≥ 640, the value of pixel_data is don't-care, but the read SHALL stay in range (word index masked or clamped).
REQ-020 The fetch FSM SHALL have states IDLE, REQ, WAIT and DRAIN.
REQ-021 The fetch FSM SHALL keep a pending-row counter (0..2) and a fetch-row counter frow (9 bits).
REQ-022 On start_frame: frow=0, pending=2, drow=0; if the state is REQ or WAIT, the FSM SHALL go to DRAIN; otherwise it SHALL stay in IDLE, or move from DRAIN to IDLE after the drain completes.
REQ-023 On start_row with frow < ROWS, pending SHALL increment; this fetches row drow+2 into the bank just released.
REQ-024 IDLE→REQ SHALL occur when pending > 0 and frow < ROWS.
REQ-025 In REQ, the block SHALL hold rd_req=1 with rd_addr = FRAME_BASE + frow×WORDS_PER_ROW + widx; widx SHALL advance on each accepted address; after widx=WORDS_PER_ROW−1 is accepted, the FSM SHALL go to WAIT.
REQ-026 Each rd_valid SHALL write rd_data to bank frow[0] at the write index, and the write index SHALL then increment.
REQ-027 In WAIT, when the last word is written: the bank valid flag for row frow SHALL be set, frow SHALL increment, pending SHALL decrement, and the FSM SHALL go to IDLE.
REQ-028 An outstanding counter (7 bits) SHALL increment on each address accept and decrement on each rd_valid; if both occur in one cycle, it SHALL be unchanged.
REQ-029 In DRAIN, rd_req SHALL be 0 and rd_valid data SHALL be discarded; when the outstanding counter reaches 0, the FSM SHALL go to IDLE and then start the new frame fill.
REQ-030 If start_row and a fetch completion fall in the same cycle, the net pending change SHALL be 0.
REQ-031 On start_frame, both bank valid flags SHALL clear.
REQ-032 On start_row, if the bank valid flag of row drow+1 is 0 and drow+1 < ROWS, underrun SHALL be set to 1; it SHALL clear only on reset.
REQ-033 rd_addr SHALL be computed in 26 bits; ROWS × WORDS_PER_ROW SHALL NOT exceed 2^26.

Reset
REQ-034 On rst_25M=1, the following SHALL be set: pixel_data=0, rd_req=0, rd_addr=0, underrun=0, state=IDLE, pending=0, frow=0, drow=0, outstanding=0, write index=0, widx=0, and both valid flags=0.
REQ-035 After reset, no fetch SHALL start until the first start_frame.
REQ-036 Reset asserted mid-fetch SHALL abandon the fetch immediately; responses arriving after reset SHALL be ignored (state IDLE, pending 0).

Verification
REQ-037 Reset, then start_frame with rd_ready=1 and a 4-cycle-latency memory model: expect 80 addresses 0..79 (row 0), then 80 addresses 80..159 (row 1), then rd_req=0.
REQ-038 With rows 0 and 1 loaded with pattern data {row, col}, sweep h_counter 0..639: expect pixel_data = lane data one cycle later, for example h_counter=9 → word 1 lane 1.
REQ-039 Issue start_row at drow=0: expect a fetch of row 2 at address 160..239 into bank 0, display bank switched to 1, and underrun still 0.
REQ-040 Issue start_row with row drow+1 still being fetched (rd_ready held 0): expect underrun=1, remaining at 1 through the next start_frame.
REQ-041 Issue start_frame while 5 responses are outstanding in REQ: expect rd_req=0 until 5 rd_valid pulses are received (discarded), then addresses restart at FRAME_BASE.
REQ-042 Issue 478 start_row pulses after a frame start: expect exactly 480 rows fetched in the frame, with no fetch of row 480.
